// File: rtl/vp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vp_pkg
// Brief  : Shared constants, opcode map and state encoding of the vector
//          sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package vp_pkg;

   localparam int LANES    = 4;
   localparam int MAX_VLEN = 16;

   localparam logic [4:0] OP_LOAD  = 5'd0;
   localparam logic [4:0] OP_STORE = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_ADD   = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SHL   = 5'd6;
   localparam logic [4:0] OP_SHR   = 5'd7;
   localparam logic [4:0] OP_ROL   = 5'd8;
   localparam logic [4:0] OP_ROR   = 5'd9;
   localparam logic [4:0] OP_AND   = 5'd10;

   localparam logic [1:0] MUX_PASS  = 2'b00;
   localparam logic [1:0] MUX_ARITH = 2'b01;
   localparam logic [1:0] MUX_XOR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ALU  = 2'd1,
      ST_MEM  = 2'd2
   } state_t;

   // Lanes enabled on the final beat; a remainder of 0 means a full beat.
   function automatic logic [LANES-1:0] tail_mask(input logic [1:0] rem);
      logic [LANES-1:0] m;
      case (rem)
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         2'd3:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Index of the final beat for an element count of 1..MAX_VLEN.
   function automatic logic [1:0] last_beat(input logic [4:0] n);
      logic [1:0] b;
      if (n > 5'd12)      b = 2'd3;
      else if (n > 5'd8)  b = 2'd2;
      else if (n > 5'd4)  b = 2'd1;
      else                b = 2'd0;
      return b;
   endfunction

endpackage : vp_pkg
`default_nettype wire

// File: rtl/decodificador_op.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : decodificador_op
// Brief  : Combinational opcode decoder: class flags, legality and ALU select.
// Rev    : 1.0  initial release
// ============================================================================
module decodificador_op
   import vp_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       is_alu,
   output logic       is_load,
   output logic       is_store,
   output logic       illegal,
   output logic [1:0] mux_key
);

   always_comb begin
      is_alu   = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      illegal  = 1'b0;
      mux_key  = MUX_PASS;
      case (opcode)
         OP_LOAD:  is_load  = 1'b1;
         OP_STORE: is_store = 1'b1;
         OP_SUB, OP_ADD: begin
            is_alu  = 1'b1;
            mux_key = MUX_ARITH;
         end
         OP_XOR: begin
            is_alu  = 1'b1;
            mux_key = MUX_XOR;
         end
         OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_AND: is_alu = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule : decodificador_op
`default_nettype wire

// File: rtl/secuenciador_vectorial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : secuenciador_vectorial
// Brief  : Splits a vector instruction into 4-lane beats for the ALU or the
//          memory port, with stall/ack handshakes and illegal detection.
// Rev    : 1.0  initial release
// ============================================================================
module secuenciador_vectorial
   import vp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [4:0] opcode,
   input  logic [2:0] vd,
   input  logic [2:0] vs1,
   input  logic [2:0] vs2,
   input  logic [4:0] vlen,
   output logic       exec_valid,
   input  logic       exec_stall,
   output logic [4:0] exec_op,
   output logic [2:0] exec_vd,
   output logic [2:0] exec_vs1,
   output logic [2:0] exec_vs2,
   output logic [1:0] exec_mux_key,
   output logic [1:0] exec_beat,
   output logic [3:0] lane_mask,
   output logic       exec_last,
   output logic       mem_req,
   output logic       mem_we,
   input  logic       mem_ack,
   output logic       wb_en,
   output logic       busy,
   output logic       illegal
);

   logic       w_is_alu;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_op_illegal;
   logic [1:0] w_mux_key;
   logic       w_reject;
   logic       w_on_last;
   logic [1:0] w_last_beat;

   state_t     r_state;
   logic [4:0] r_op;
   logic [2:0] r_vd;
   logic [2:0] r_vs1;
   logic [2:0] r_vs2;
   logic [4:0] r_vlen;
   logic [1:0] r_mux_key;
   logic       r_is_load;
   logic       r_is_store;
   logic [1:0] r_beat;
   logic       r_illegal;

   decodificador_op u_dec (
      .opcode   (opcode),
      .is_alu   (w_is_alu),
      .is_load  (w_is_load),
      .is_store (w_is_store),
      .illegal  (w_op_illegal),
      .mux_key  (w_mux_key)
   );

   assign w_reject    = w_op_illegal || (vlen > 5'(MAX_VLEN));
   assign w_last_beat = last_beat(r_vlen);
   assign w_on_last   = (r_beat == w_last_beat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_vd       <= '0;
         r_vs1      <= '0;
         r_vs2      <= '0;
         r_vlen     <= '0;
         r_mux_key  <= MUX_PASS;
         r_is_load  <= 1'b0;
         r_is_store <= 1'b0;
         r_beat     <= '0;
         r_illegal  <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  r_op       <= opcode;
                  r_vd       <= vd;
                  r_vs1      <= vs1;
                  r_vs2      <= vs2;
                  r_vlen     <= vlen;
                  r_mux_key  <= w_mux_key;
                  r_is_load  <= w_is_load;
                  r_is_store <= w_is_store;
                  r_beat     <= '0;
                  // Rejected or empty instructions retire here without a beat.
                  if (w_reject)
                     r_illegal <= 1'b1;
                  else if (vlen != 5'd0)
                     r_state <= w_is_alu ? ST_ALU : ST_MEM;
               end
            end
            ST_ALU: begin
               if (!exec_stall) begin
                  if (w_on_last) begin
                     r_state <= ST_IDLE;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  if (w_on_last) begin
                     r_state <= ST_IDLE;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready  = (r_state == ST_IDLE);
   assign busy         = (r_state != ST_IDLE);
   assign exec_valid   = (r_state == ST_ALU);
   assign mem_req      = (r_state == ST_MEM);
   assign mem_we       = mem_req && r_is_store;
   assign wb_en        = mem_req && r_is_load && mem_ack;
   assign illegal      = r_illegal;

   assign exec_op      = r_op;
   assign exec_vd      = r_vd;
   assign exec_vs1     = r_vs1;
   assign exec_vs2     = r_vs2;
   assign exec_mux_key = r_mux_key;
   assign exec_beat    = r_beat;
   assign exec_last    = busy && w_on_last;
   assign lane_mask    = !busy     ? 4'b0000 :
                         w_on_last ? tail_mask(r_vlen[1:0]) : 4'b1111;

endmodule : secuenciador_vectorial
`default_nettype wire

// File: doc/secuenciador_vectorial.md
SECUENCIADOR_VECTORIAL -- requirements
Module: secuenciador_vectorial

Interface
REQ-001 The block SHALL have no parameters; LANES=4 and MAX_VLEN=16 SHALL come from the shared package.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- opcode  in  5  vector opcode
- vd, vs1, vs2  in  3 each  vector register indices
- vlen  in  5  element count, 0..31
- exec_valid  out  1  ALU beat issued this cycle
- exec_stall  in  1  datapath cannot take a beat
- exec_op  out  5  latched opcode
- exec_vd, exec_vs1, exec_vs2  out  3 each  latched register indices
- exec_mux_key  out  2  ALU result select
- exec_beat  out  2  current beat index
- lane_mask  out  4  active lanes in the current beat
- exec_last  out  1  final beat of the instruction
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = store, 0 = load
- mem_ack  in  1  memory beat complete
- wb_en  out  1  load writeback strobe
- busy  out  1  instruction in progress
- illegal  out  1  one-cycle illegal-instruction pulse

Function
REQ-004 The legal opcodes SHALL be 0 LOAD, 1 STORE, 2 SUB, 3 ADD, 4 XOR, 6 SHL, 7 SHR, 8 ROL, 9 ROR and 10 AND; every other opcode SHALL be illegal.
REQ-005 exec_mux_key SHALL be 01 for SUB/ADD, 10 for XOR and 00 for all other opcodes.
REQ-006 The state machine SHALL have the states IDLE, ALU and MEM; instr_ready SHALL be 1 only in IDLE, and busy SHALL equal !IDLE.
REQ-007 An instruction SHALL be accepted on an edge where instr_valid && instr_ready; opcode, register indices and vlen SHALL be latched on that edge.
REQ-008 On acceptance of an illegal opcode, or of vlen>16, illegal SHALL pulse high for exactly the next cycle, no beat SHALL issue, and the state SHALL remain IDLE.
REQ-009 On acceptance with vlen=0, the instruction SHALL complete with no beat and no pulse, and the state SHALL remain IDLE.
REQ-010 The beat count SHALL be ceil(vlen/4), giving 1..4 beats.
REQ-011 lane_mask SHALL be 1111 on every beat except the last; on the last beat its low (vlen mod 4) bits SHALL be set, or all four bits when vlen mod 4 = 0.
REQ-012 After acceptance, an ALU opcode SHALL enter ALU and a LOAD or STORE SHALL enter MEM; the first beat SHALL appear in the cycle after acceptance.
REQ-013 ALU: exec_valid SHALL be 1 in every ALU cycle.
REQ-014 ALU: a beat SHALL retire on an edge with exec_stall=0; while exec_stall=1, all exec_* outputs SHALL hold.
REQ-015 ALU: exec_last SHALL be 1 on the final beat; retiring the final beat SHALL return the state to IDLE.
REQ-016 MEM: mem_req SHALL be 1 and mem_we SHALL equal (opcode==STORE); exec_beat and lane_mask SHALL be valid.
REQ-017 MEM: a beat SHALL retire on an edge with mem_ack=1; with mem_ack=0 the request SHALL hold indefinitely.
REQ-018 For a LOAD, wb_en SHALL equal mem_req && mem_ack; for a STORE, wb_en SHALL be 0.
REQ-019 mem_ack SHALL be ignored outside MEM, and exec_stall SHALL be ignored outside ALU.
REQ-020 A back-to-back instruction SHALL be accepted no earlier than the cycle after the final beat retires (one IDLE cycle).

Reset
REQ-021 rst_n low SHALL abort any instruction immediately, asynchronously.
REQ-022 During reset the state SHALL be IDLE, the beat counter and latched fields SHALL be 0, and all outputs SHALL be 0 except instr_ready=1.
REQ-023 After rst_n rises, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-024 Package vp_pkg SHALL hold the opcode constants, the state enum, LANES, MAX_VLEN and the mux_key encodings.
REQ-025 One combinational sub-module, decodificador_op, SHALL map opcode to {is_alu, is_load, is_store, illegal, mux_key}.

Verification
REQ-026 ADD, vlen=7, no stall -> exec_valid high for 2 consecutive cycles, lane_mask 1111 then 0111, exec_last on beat 1, instr_ready again 1 cycle later.
REQ-027 XOR, vlen=16, exec_stall high for 3 cycles at beat 2 -> 4 beats over 7 cycles, beat-2 outputs held constant, exec_mux_key=10 throughout.
REQ-028 LOAD, vlen=5, mem_ack delayed 2 cycles per beat -> mem_req high 6 cycles, mem_we=0, two wb_en pulses, lane_mask 1111 then 0001.
REQ-029 Opcode 5, then opcode 11 with vlen=3, then SUB with vlen=20 -> one illegal pulse each, no exec_valid or mem_req, instr_ready stays 1.
REQ-030 STORE, vlen=12, rst_n asserted mid-beat 1 -> mem_req drops asynchronously, all outputs at reset values, a new ADD is accepted after release.
